inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//  Front end that feeds the decode stage: fetches 32-bit instructions byte-by-byte over the 8-bit memory port.
//  Each fetched word is pushed with its PC and a static taken/not-taken prediction into an instruction queue.
//  The queue head is presented combinationally to decode, which pops it on issue.
//  ROB misprediction recovery flushes the queue and redirects the PC.
// PARAMETERS
//  IQ_DEPTH  16          queue entries, power of 2 (>=2)
//  RESET_PC  32'h0       PC loaded at reset
// PORTS
//  clk                 in   1   clock, all state on posedge
//  rst_n               in   1   asynchronous active-low reset
//  out_mem_req         out  1   byte read request
//  out_mem_addr        out  32  byte address of request
//  in_mem_grant        in   1   request accepted this cycle
//  in_mem_valid        in   1   in_mem_data valid (exactly 1 cycle after a grant)
//  in_mem_data         in   8   returned byte
//  in_issue_ena        in   1   decode consumes queue head this cycle
//  out_valid           out  1   queue non-empty
//  out_inst            out  32  head instruction
//  out_pc              out  32  head PC
//  out_predicted_taken out  1   head prediction
//  in_flush            in   1   misprediction: discard everything
//  in_flush_pc         in   32  redirect target
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC; queue empty (head=tail=count=0); state IDLE; req/rcv counters 0.
//   - out_mem_req=0, out_mem_addr=0, out_valid=0; out_inst/out_pc=0; out_predicted_taken=0.
//  FSM IDLE -> FETCH:
//   - IDLE: out_mem_req=0; in_mem_valid ignored.
//   - Go to FETCH when count<IQ_DEPTH and !in_flush; clear req_cnt and rcv_cnt.
//  FETCH, requests:
//   - out_mem_req=1 while req_cnt<4, with out_mem_addr=pc+req_cnt.
//   - Each in_mem_grant increments req_cnt.
//  FETCH, returns:
//   - Each in_mem_valid stores in_mem_data into byte lane rcv_cnt (little-endian) and increments rcv_cnt.
//   - On the 4th byte, on the same edge: push {inst, pc, pred} at tail, pc<=next_pc, state<=IDLE.
//  Latency (grants every cycle, queue empty):
//   - IDLE at cycle 0; grants cycles 1-4; bytes cycles 2-5; push at end of cycle 5; out_valid=1 in cycle 6.
//  Prediction (combinational on the assembled word):
//   - JAL: taken, next=pc+J_IMM.
//   - BRANCH with inst[31]=1 (backward): taken, next=pc+B_IMM.
//   - Otherwise, including JALR: not taken, next=pc+4. All 32-bit wrap-around.
//  Queue:
//   - Pop when in_issue_ena && out_valid; in_issue_ena with the queue empty is ignored.
//   - Push and pop in the same cycle: count unchanged.
//   - Push never occurs when full, because a fetch starts only with free space and a fetch is never overlapped.
//   - Pointers wrap modulo IQ_DEPTH.
//  Flush (highest priority):
//   - Next cycle: queue empty, state IDLE, pc=in_flush_pc, counters cleared.
//   - Push or pop in the flush cycle is dropped.
//   - A request granted in the flush cycle returns its byte while IDLE, and that byte is discarded.
//   - out_mem_req may be 1 in the flush cycle (harmless).
//   - Flush while IDLE, or repeated flushes: the last in_flush_pc wins.
//  Reset mid-fetch: everything returns to reset values immediately; late bytes are ignored in IDLE.
// STRUCTURE
//  Shared constants (constant.v): opcodes (JAL_OP, BRANCH_OP, OP_RANGE), DATA_WIDTH, INSTRUCTION_WIDTH, TRUE/FALSE.
//  Shared immediate encodings, reused by decode: J_IMM and B_IMM extraction macros.
//  Sub-module inst_queue: synchronous circular FIFO of {inst, pc, pred}.
//   - Parameter IQ_DEPTH; async reset; push/pop/flush inputs; head outputs; full/empty/count.
//  Top level: fetch FSM, byte assembler, static predictor.
// TESTING
//  1. Reset, memory holds 0x00000013 at 0, grant=1 always -> addrs 0,1,2,3 in cycles 1-4; out_valid=1 cycle 6, out_inst=0x00000013, out_pc=0, pred=0; next fetch addr 4.
//  2. JAL x0,-8 (0xFF9FF06F) at pc 0x10 -> pred=1, next fetch addr 0x08; BEQ forward (inst[31]=0) at 0x20 -> pred=0, next 0x24.
//  3. Hold in_issue_ena=0, IQ_DEPTH=4 -> exactly 4 entries pushed, out_mem_req stays 0; one pop -> exactly one more fetch.
//  4. Assert in_flush with in_flush_pc=0x100 during cycle 3 of a fetch -> out_valid=0 next cycle, stale byte dropped, next out_mem_addr=0x100, first entry out_pc=0x100.
//  5. Grant toggling 1,0,1,0 -> address sequence pc+0..pc+3 holds during stalls; inst correctly assembled; push + simultaneous pop keeps count.
//  6. rst_n low mid-fetch with the queue half full -> all outputs 0 asynchronously; refetch from RESET_PC after release.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetcher_pkg
// Description : Shared types and constants for the instruction fetch front
//               end: opcode values, FSM state encoding, instruction-queue
//               entry layout and the J/B immediate extractors that decode
//               reuses.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetcher_pkg;

    localparam int c_DATA_WIDTH = 8;
    localparam int c_INST_WIDTH = 32;

    localparam logic [6:0] c_JAL_OP    = 7'b1101111;
    localparam logic [6:0] c_BRANCH_OP = 7'b1100011;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [c_INST_WIDTH-1:0] inst;
        logic [31:0]             pc;
        logic                    pred;
    } iq_entry_t;

    function automatic logic [6:0] opcode(input logic [c_INST_WIDTH-1:0] inst);
        return inst[6:0];
    endfunction

    // JAL offset: imm[20|10:1|11|19:12] scattered over inst[31:12]
    function automatic logic [31:0] j_imm(input logic [c_INST_WIDTH-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Branch offset: imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7]
    function automatic logic [31:0] b_imm(input logic [c_INST_WIDTH-1:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue
// Description : Synchronous circular FIFO of {inst, pc, pred} entries. The
//               head entry is presented combinationally (zero when empty).
// Ports       : clk, rst_n        clock, async active-low reset
//               i_push, i_data    write an entry at the tail
//               i_pop             consume the head (ignored when empty)
//               i_flush           discard all entries; overrides push/pop
//               o_head            head entry
//               o_full, o_empty   occupancy flags
//               o_count           number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter  int IQ_DEPTH = 16,
    localparam int c_AW     = $clog2(IQ_DEPTH),
    localparam int c_CW     = c_AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  iq_entry_t       i_data,
    input  logic            i_pop,
    input  logic            i_flush,
    output iq_entry_t       o_head,
    output logic            o_full,
    output logic            o_empty,
    output logic [c_CW-1:0] o_count
);

    iq_entry_t         r_mem [IQ_DEPTH];
    logic [c_AW-1:0]   r_head;
    logic [c_AW-1:0]   r_tail;
    logic [c_CW-1:0]   r_count;

    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == c_CW'(IQ_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = o_empty ? '0 : r_mem[r_head];

    assign w_do_push = i_push && !i_flush && !o_full;
    assign w_do_pop  = i_pop  && !i_flush && !o_empty;

    // Storage carries no reset; validity is tracked by r_count alone
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + c_AW'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetcher
// Description : Fetch front end. Reads each 32-bit instruction as four byte
//               requests on an 8-bit memory port, assembles it little-endian,
//               applies a static prediction (JAL and backward branches taken)
//               and pushes {inst, pc, pred} into the instruction queue whose
//               head feeds decode. A flush empties the queue and redirects.
// Ports       : clk, rst_n                  clock, async active-low reset
//               out_mem_req/out_mem_addr    byte read request / address
//               in_mem_grant                request accepted this cycle
//               in_mem_valid/in_mem_data    returned byte (1 cycle after grant)
//               in_issue_ena                decode pops the queue head
//               out_valid/out_inst/out_pc/
//               out_predicted_taken         queue head presented to decode
//               in_flush/in_flush_pc        misprediction redirect
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    out_mem_req,
    output logic [31:0]             out_mem_addr,
    input  logic                    in_mem_grant,
    input  logic                    in_mem_valid,
    input  logic [c_DATA_WIDTH-1:0] in_mem_data,
    input  logic                    in_issue_ena,
    output logic                    out_valid,
    output logic [c_INST_WIDTH-1:0] out_inst,
    output logic [31:0]             out_pc,
    output logic                    out_predicted_taken,
    input  logic                    in_flush,
    input  logic [31:0]             in_flush_pc
);

    localparam int c_CW = $clog2(IQ_DEPTH) + 1;

    fetch_state_t                r_state;
    logic [31:0]                 r_pc;
    logic [2:0]                  r_req_cnt;
    logic [1:0]                  r_rcv_cnt;
    logic [3*c_DATA_WIDTH-1:0]   r_bytes;

    logic                        w_req;
    logic                        w_last_byte;
    logic                        w_push;
    logic                        w_pred;
    logic [31:0]                 w_next_pc;
    logic [c_INST_WIDTH-1:0]     w_inst;
    logic                        w_full;
    logic                        w_empty;
    logic [c_CW-1:0]             w_count;
    iq_entry_t                   w_head;
    iq_entry_t                   w_push_data;

    // ------------------------------------------------------------------
    // Memory request side
    // ------------------------------------------------------------------
    assign w_req        = (r_state == S_FETCH) && (r_req_cnt < 3'd4);
    assign out_mem_req  = w_req;
    assign out_mem_addr = w_req ? (r_pc + {29'd0, r_req_cnt}) : '0;

    // The fourth byte is used straight off the bus so the word can be
    // pushed on the same edge it arrives
    assign w_inst       = {in_mem_data, r_bytes};
    assign w_last_byte  = (r_state == S_FETCH) && in_mem_valid && (r_rcv_cnt == 2'd3);
    assign w_push       = w_last_byte && !w_full;

    // ------------------------------------------------------------------
    // Static predictor on the assembled word
    // ------------------------------------------------------------------
    always_comb begin
        w_pred    = 1'b0;
        w_next_pc = r_pc + 32'd4;
        if (opcode(w_inst) == c_JAL_OP) begin
            w_pred    = 1'b1;
            w_next_pc = r_pc + j_imm(w_inst);
        end else if ((opcode(w_inst) == c_BRANCH_OP) && w_inst[31]) begin
            w_pred    = 1'b1;
            w_next_pc = r_pc + b_imm(w_inst);
        end
    end

    assign w_push_data = '{inst: w_inst, pc: r_pc, pred: w_pred};

    // ------------------------------------------------------------------
    // Fetch FSM and byte assembler
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_req_cnt <= '0;
            r_rcv_cnt <= '0;
            r_bytes   <= '0;
        end else if (in_flush) begin
            r_state   <= S_IDLE;
            r_pc      <= in_flush_pc;
            r_req_cnt <= '0;
            r_rcv_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Starting only with free space is what guarantees a
                    // push never meets a full queue
                    if (w_count < c_CW'(IQ_DEPTH)) begin
                        r_state   <= S_FETCH;
                        r_req_cnt <= '0;
                        r_rcv_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_req && in_mem_grant) begin
                        r_req_cnt <= r_req_cnt + 3'd1;
                    end
                    if (in_mem_valid) begin
                        r_rcv_cnt <= r_rcv_cnt + 2'd1;
                        case (r_rcv_cnt)
                            2'd0:    r_bytes[7:0]   <= in_mem_data;
                            2'd1:    r_bytes[15:8]  <= in_mem_data;
                            2'd2:    r_bytes[23:16] <= in_mem_data;
                            default: begin
                                r_pc    <= w_next_pc;
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Instruction queue
    // ------------------------------------------------------------------
    inst_queue #(
        .IQ_DEPTH (IQ_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (in_issue_ena),
        .i_flush (in_flush),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign out_valid           = !w_empty;
    assign out_inst            = w_head.inst;
    assign out_pc              = w_head.pc;
    assign out_predicted_taken = w_head.pred;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetcher
// Description : Self-checking bench for inst_fetcher (IQ_DEPTH=4). A byte
//               memory model answers requests; expected queue entries are
//               generated from the memory image and compared on issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetcher;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        out_mem_req;
    logic [31:0] out_mem_addr;
    logic        in_mem_grant = 1'b0;
    logic        in_mem_valid = 1'b0;
    logic [7:0]  in_mem_data = 8'h00;
    logic        in_issue_ena = 1'b0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_predicted_taken;
    logic        in_flush = 1'b0;
    logic [31:0] in_flush_pc = 32'h0;

    int          errors = 0;
    int          checks = 0;

    logic [7:0]  mem [logic [31:0]];
    logic [64:0] exp_q [$];
    logic [31:0] grant_log [$];
    logic [32:0] req_log [$];
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          gmode = 0;

    always #5 clk = ~clk;

    inst_fetcher #(
        .IQ_DEPTH (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .out_mem_req         (out_mem_req),
        .out_mem_addr        (out_mem_addr),
        .in_mem_grant        (in_mem_grant),
        .in_mem_valid        (in_mem_valid),
        .in_mem_data         (in_mem_data),
        .in_issue_ena        (in_issue_ena),
        .out_valid           (out_valid),
        .out_inst            (out_inst),
        .out_pc              (out_pc),
        .out_predicted_taken (out_predicted_taken),
        .in_flush            (in_flush),
        .in_flush_pc         (in_flush_pc)
    );

    function automatic logic [7:0] rdb(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    function automatic logic [31:0] rdw(input logic [31:0] a);
        return {rdb(a + 32'd3), rdb(a + 32'd2), rdb(a + 32'd1), rdb(a)};
    endfunction

    task automatic put_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    // Memory model, mid-cycle: returns the byte granted last cycle, chooses
    // this cycle's grant, and logs requests.
    always @(negedge clk) begin
        in_mem_valid = pend;
        in_mem_data  = rdb(pend_addr);
        if (gmode == 0) in_mem_grant = 1'b1;
        else            in_mem_grant = ~in_mem_grant;
        pend      = out_mem_req && in_mem_grant;
        pend_addr = out_mem_addr;
        if (out_mem_req) begin
            req_log.push_back({in_mem_grant, out_mem_addr});
            if (in_mem_grant) grant_log.push_back(out_mem_addr);
        end
    end

    // Reference: walk the program from start, predicting as decode expects
    task automatic sb_load(input logic [31:0] start, input int n);
        logic [31:0] pc, w, j, b, npc;
        logic        p;
        pc = start;
        for (int k = 0; k < n; k++) begin
            w = rdw(pc);
            j = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            b = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            if (w[6:0] == 7'h6F) begin
                p = 1'b1; npc = pc + j;
            end else if (w[6:0] == 7'h63 && w[31]) begin
                p = 1'b1; npc = pc + b;
            end else begin
                p = 1'b0; npc = pc + 32'd4;
            end
            exp_q.push_back({w, pc, p});
            pc = npc;
        end
    endtask

    task automatic pop_head(output logic [64:0] got, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        got = '0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (out_valid) begin
            got = {out_inst, out_pc, out_predicted_taken};
            ok  = 1'b1;
            in_issue_ena = 1'b1;
            @(negedge clk);
            in_issue_ena = 1'b0;
        end
    endtask

    task automatic do_flush(input logic [31:0] pc);
        in_flush    = 1'b1;
        in_flush_pc = pc;
        @(negedge clk);
        in_flush = 1'b0;
        grant_log.delete();
        req_log.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [64:0] got, exp;
        bit          ok;
        logic        e_req;
        logic [31:0] e_addr;
        gmode = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_mem_req, out_mem_addr, out_valid, out_inst, out_pc, out_predicted_taken} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h valid=%b inst=%h pc=%h pred=%b, all required 0",
                     out_mem_req, out_mem_addr, out_valid, out_inst, out_pc, out_predicted_taken);
        end
        rst_n = 1'b1;
        exp_q.delete();
        sb_load(32'h0, 1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            e_req  = (c <= 4) || (c == 7);
            e_addr = (c <= 4) ? 32'(c - 1) : ((c == 7) ? 32'h4 : 32'h0);
            checks++;
            if (out_mem_req !== e_req || out_mem_addr !== e_addr) begin
                errors++;
                $display("FAIL latency_req cycle %0d: req=%b addr=%h, expected req=%b addr=%h",
                         c, out_mem_req, out_mem_addr, e_req, e_addr);
            end
            checks++;
            if (out_valid !== (c >= 6)) begin
                errors++;
                $display("FAIL latency_valid cycle %0d: valid=%b, expected %b", c, out_valid, (c >= 6));
            end
        end
        pop_head(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL first_entry: got %h (ok=%0d), expected %h", got, ok, exp);
        end
    endtask

    task automatic test_predict();
        logic [64:0] got, exp;
        bit          ok;
        logic [31:0] starts [4];
        logic [31:0] nexts  [4];
        starts = '{32'h10, 32'h20, 32'h40, 32'h60};
        nexts  = '{32'h08, 32'h24, 32'h38, 32'h64};
        for (int t = 0; t < 4; t++) begin
            do_flush(starts[t]);
            sb_load(starts[t], 2);
            for (int k = 0; k < 2; k++) begin
                pop_head(got, ok);
                exp = exp_q.pop_front();
                checks++;
                if (!ok || got !== exp) begin
                    errors++;
                    $display("FAIL predict_entry pc=%h #%0d: got %h (ok=%0d), expected %h",
                             starts[t], k, got, ok, exp);
                end
            end
            checks++;
            if (grant_log.size() < 5 || grant_log[4] !== nexts[t]) begin
                errors++;
                $display("FAIL predict_next_addr from %h: got %h (log size %0d), expected %h",
                         starts[t], (grant_log.size() > 4) ? grant_log[4] : 32'hx,
                         grant_log.size(), nexts[t]);
            end
        end
    endtask

    task automatic test_full();
        logic [64:0] got, exp;
        bit          ok;
        int          nreq;
        do_flush(32'h0);
        sb_load(32'h0, 5);
        repeat (40) @(negedge clk);
        checks++;
        if (grant_log.size() != 16) begin
            errors++;
            $display("FAIL full_grants: got %0d grants, expected 16", grant_log.size());
        end
        nreq = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_mem_req) nreq++;
        end
        checks++;
        if (nreq != 0) begin
            errors++;
            $display("FAIL full_req_idle: req high %0d cycles, expected 0", nreq);
        end
        pop_head(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL full_pop0: got %h (ok=%0d), expected %h", got, ok, exp);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (grant_log.size() != 20 || out_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL full_one_refetch: got %0d grants req=%b, expected 20 grants req=0",
                     grant_log.size(), out_mem_req);
        end
        for (int k = 1; k < 5; k++) begin
            pop_head(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL full_pop%0d: got %h (ok=%0d), expected %h", k, got, ok, exp);
            end
        end
    endtask

    task automatic test_flush();
        logic [64:0] got, exp;
        bit          ok;
        int          n;
        do_flush(32'h0);
        n = 0;
        while (!(out_mem_req && out_mem_addr == 32'h0A) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(out_mem_req && out_mem_addr == 32'h0A) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: req=%b addr=%h valid=%b, expected req=1 addr=0000000a valid=1",
                     out_mem_req, out_mem_addr, out_valid);
        end
        in_flush    = 1'b1;
        in_flush_pc = 32'h100;
        @(negedge clk);
        in_flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: valid=%b req=%b, expected 0 0", out_valid, out_mem_req);
        end
        exp_q.delete();
        sb_load(32'h100, 2);
        @(negedge clk);
        checks++;
        if (out_mem_req !== 1'b1 || out_mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL flush_redirect: req=%b addr=%h, expected req=1 addr=00000100",
                     out_mem_req, out_mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            pop_head(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL flush_entry%0d: got %h (ok=%0d), expected %h", k, got, ok, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] got, exp;
        bit          ok;
        int          g;
        // Alternating grants: addresses hold through stalls
        gmode = 1;
        do_flush(32'h100);
        sb_load(32'h100, 2);
        for (int k = 0; k < 2; k++) begin
            pop_head(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL toggle_entry%0d: got %h (ok=%0d), expected %h", k, got, ok, exp);
            end
        end
        g = 0;
        for (int i = 0; i < req_log.size() && g < 4; i++) begin
            checks++;
            if (req_log[i][31:0] !== 32'h100 + 32'(g)) begin
                errors++;
                $display("FAIL toggle_addr req#%0d: got %h, expected %h",
                         i, req_log[i][31:0], 32'h100 + 32'(g));
            end
            if (req_log[i][32]) g++;
        end
        // Push and pop on the same edge leave the count unchanged
        gmode = 0;
        do_flush(32'h100);
        sb_load(32'h100, 2);
        repeat (11) @(negedge clk);
        got = {out_inst, out_pc, out_predicted_taken};
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL pushpop_head0: valid=%b got %h, expected valid=1 %h", out_valid, got, exp);
        end
        in_issue_ena = 1'b1;
        @(negedge clk);
        in_issue_ena = 1'b0;
        got = {out_inst, out_pc, out_predicted_taken};
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL pushpop_head1: valid=%b got %h, expected valid=1 %h", out_valid, got, exp);
        end
        in_issue_ena = 1'b1;
        @(negedge clk);
        in_issue_ena = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_count: valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [64:0] got, exp;
        bit          ok;
        int          n;
        gmode = 0;
        do_flush(32'h0);
        n = 0;
        while (!(out_mem_req && out_mem_addr == 32'h09) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_mem_addr !== 32'h09) begin
            errors++;
            $display("FAIL rstmid_setup: valid=%b addr=%h, expected valid=1 addr=00000009",
                     out_valid, out_mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_mem_req, out_mem_addr, out_valid, out_inst, out_pc, out_predicted_taken} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: req=%b addr=%h valid=%b inst=%h pc=%h pred=%b, all required 0",
                     out_mem_req, out_mem_addr, out_valid, out_inst, out_pc, out_predicted_taken);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        sb_load(32'h0, 2);
        @(negedge clk);
        checks++;
        if (out_mem_req !== 1'b1 || out_mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_refetch: req=%b addr=%h, expected req=1 addr=00000000",
                     out_mem_req, out_mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            pop_head(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL rstmid_entry%0d: got %h (ok=%0d), expected %h", k, got, ok, exp);
            end
        end
    endtask

    initial begin
        put_word(32'h00, 32'h00000013);
        put_word(32'h08, 32'h00000013);
        put_word(32'h0C, 32'h00000013);
        put_word(32'h10, 32'hFF9FF06F);   // jal x0, -8
        put_word(32'h20, 32'h00000463);   // beq x0, x0, +8 (forward)
        put_word(32'h40, 32'hFE000CE3);   // beq x0, x0, -8 (backward)
        put_word(32'h60, 32'hFFC08067);   // jalr x0, -4(x1)
        put_word(32'h100, 32'h12345678);
        put_word(32'h104, 32'hCAFEBABE);

        test_reset();
        test_predict();
        test_full();
        test_flush();
        test_back_to_back();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
